// File: rtl/ps2_host_tx_pkg.sv
// Shared types and command bytes for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  // {stop, odd parity, data}; shifted out LSB first
  function automatic logic [9:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one PS/2 line.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter with ACK/NACK/timeout reporting.
// Optional PS2_TX_RETRY_EN: retry failed attempts up to MAX_RETRY times.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int REQ_TIMEOUT    = 1500000,
  parameter int BIT_TIMEOUT    = 200000,
`ifdef PS2_TX_RETRY_EN
  parameter int MAX_RETRY      = 2,
`endif
  parameter int FILTER_LEN     = 8
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
`ifdef PS2_TX_RETRY_EN
  output logic [1:0] retry_cnt,
`endif
  output logic       err_timeout
);

  localparam int TW = $clog2(REQ_TIMEOUT + 1);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] REQ_LAST = TW'(REQ_TIMEOUT - 1);
  localparam logic [TW-1:0] BIT_LAST = TW'(BIT_TIMEOUT - 1);

  ps2_tx_state_t state, state_n;
  logic [9:0]    shreg, shreg_n;
  logic [3:0]    edge_cnt, edge_n;
  logic [TW-1:0] timer, timer_n;
  logic          drive, drive_n;
  logic          ack_n, err_n, done_n;
  logic          clk_f, data_f, clk_prev, fall;
  logic          take_bit, tmo, fin;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    retries, retries_n;
  logic [7:0]    byte_q, byte_n;
`endif

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .CLK100MHZ(CLK100MHZ),
    .rst      (rst),
    .raw      (ps2_clk_in),
    .level    (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .CLK100MHZ(CLK100MHZ),
    .rst      (rst),
    .raw      (ps2_data_in),
    .level    (data_f)
  );

  assign fall     = clk_prev & ~clk_f;
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign ps2_clk_oe = (state == INHIBIT);
`ifdef PS2_TX_RETRY_EN
  assign retry_cnt = retries;
`endif

  always_comb begin
    ps2_data_oe = 1'b0;
    unique case (state)
      INHIBIT:    ps2_data_oe = (timer == INH_LAST);
      REQ:        ps2_data_oe = 1'b1;
      SHIFT, ACK: ps2_data_oe = drive;
      default:    ps2_data_oe = 1'b0;
    endcase
  end

  always_comb begin
    state_n  = state;
    shreg_n  = shreg;
    edge_n   = edge_cnt;
    timer_n  = (timer == '1) ? timer : timer + 1'b1;
    drive_n  = drive;
    ack_n    = ack_ok;
    err_n    = err_timeout;
    done_n   = 1'b0;
    take_bit = 1'b0;
    tmo      = 1'b0;
    fin      = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retries_n = retries;
    byte_n    = byte_q;
`endif
    unique case (state)
      IDLE: begin
        if (tx_valid) begin
          state_n = INHIBIT;
          shreg_n = ps2_frame(tx_data);
          edge_n  = '0;
          timer_n = '0;
          drive_n = 1'b0;
          ack_n   = 1'b0;
          err_n   = 1'b0;
`ifdef PS2_TX_RETRY_EN
          retries_n = '0;
          byte_n    = tx_data;
`endif
        end
      end
      INHIBIT: begin
        if (timer == INH_LAST) begin
          state_n = REQ;
          timer_n = '0;
        end
      end
      REQ: begin
        if (fall) take_bit = 1'b1;
        else if (timer == REQ_LAST) tmo = 1'b1;
      end
      SHIFT: begin
        if (fall) take_bit = 1'b1;
        else if (timer == BIT_LAST) tmo = 1'b1;
      end
      ACK: begin
        if (fall) begin
          ack_n   = ~data_f;
          state_n = WAIT_IDLE;
          timer_n = '0;
        end else if (timer == BIT_LAST) begin
          tmo = 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (clk_f && data_f) fin = 1'b1;
        else if (timer == BIT_LAST) tmo = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // fall 10 shifts out the stop bit, so drive goes low (release)
    if (take_bit) begin
      drive_n = ~shreg[0];
      shreg_n = {1'b0, shreg[9:1]};
      edge_n  = edge_cnt + 1'b1;
      timer_n = '0;
      state_n = (edge_cnt == 4'd9) ? ACK : SHIFT;
    end

    if (tmo) begin
      drive_n = 1'b0;
      ack_n   = 1'b0;
      err_n   = 1'b1;
      fin     = 1'b1;
    end

    if (fin) begin
`ifdef PS2_TX_RETRY_EN
      if (!ack_n && int'(retries) < MAX_RETRY) begin
        state_n   = INHIBIT;
        timer_n   = '0;
        edge_n    = '0;
        drive_n   = 1'b0;
        shreg_n   = ps2_frame(byte_q);
        retries_n = retries + 2'd1;
        ack_n     = 1'b0;
        err_n     = 1'b0;
      end else
`endif
      begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      edge_cnt    <= '0;
      timer       <= '0;
      drive       <= 1'b0;
      ack_ok      <= 1'b0;
      err_timeout <= 1'b0;
      done        <= 1'b0;
      clk_prev    <= 1'b1;
`ifdef PS2_TX_RETRY_EN
      retries     <= '0;
      byte_q      <= '0;
`endif
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      edge_cnt    <= edge_n;
      timer       <= timer_n;
      drive       <= drive_n;
      ack_ok      <= ack_n;
      err_timeout <= err_n;
      done        <= done_n;
      clk_prev    <= clk_f;
`ifdef PS2_TX_RETRY_EN
      retries     <= retries_n;
      byte_q      <= byte_n;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
module tb_ps2_host_tx;

  localparam int INH  = 300;
  localparam int REQT = 3000;
  localparam int BITT = 1500;
  localparam int FILT = 8;
  localparam int HALF = 40;
  localparam int LONG = 300;

  logic       CLK100MHZ = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, ack_ok, err_timeout;
  logic       ps2_clk_oe, ps2_data_oe, ps2_clk_in, ps2_data_in;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic [1:0] rcnt;

  assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_in = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .REQ_TIMEOUT   (REQT),
    .BIT_TIMEOUT   (BITT),
    .FILTER_LEN    (FILT)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
`ifdef PS2_TX_RETRY_EN
    .retry_cnt  (rcnt),
`endif
    .err_timeout(err_timeout)
  );

`ifndef PS2_TX_RETRY_EN
  assign rcnt = 2'd0;
`endif

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int accept_cyc = 0;
  int inh_phases = 0;
  int inh_len = 0;
  logic inh_d_last = 1'b0;
  logic inh_d_prev = 1'b0;
  int dev_fall_n = 0;
  bit dev_abort = 1'b0;
  bit dev_off = 1'b0;

  // done vector: {ack_ok, err_timeout, clk_in, data_in, clk_oe, data_oe, retry[1:0]}
  logic [7:0] exp_done_q[$];
  logic [9:0] exp_frame_q[$];
  bit         dev_mode_q[$];

  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // done monitor
  initial begin
    logic [7:0] e, g;
    forever begin
      @(negedge CLK100MHZ);
      if (!rst && done) begin
        done_cnt++;
        done_cyc = cyc;
        g = {ack_ok, err_timeout, ps2_clk_in, ps2_data_in,
             ps2_clk_oe, ps2_data_oe, rcnt};
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", {24'd0, g}, 32'hFFFF_FFFF);
        end else begin
          e = exp_done_q.pop_front();
          check("done_result", {24'd0, g}, {24'd0, e});
        end
      end
    end
  end

  // inhibit-phase monitor
  initial begin
    int run;
    logic cur, prv;
    run = 0; cur = 1'b0; prv = 1'b0;
    forever begin
      @(negedge CLK100MHZ);
      if (ps2_clk_oe) begin
        run++;
        prv = cur;
        cur = ps2_data_oe;
      end else if (run != 0) begin
        inh_len = run;
        inh_d_last = cur;
        inh_d_prev = prv;
        inh_phases++;
        run = 0; cur = 1'b0; prv = 1'b0;
      end
    end
  end

  task automatic dev_wait(input int n, output bit ab);
    ab = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK100MHZ);
      if (dev_abort) begin
        ab = 1'b1;
        break;
      end
    end
  endtask

  task automatic dev_frame();
    logic [9:0] bits;
    logic [9:0] ef;
    bit ab, nack;
    nack = (dev_mode_q.size() != 0) ? dev_mode_q.pop_front() : 1'b0;
    bits = '0;
    dev_wait(20, ab);
    for (int n = 1; n <= 10 && !ab; n++) begin
      dev_clk = 1'b0;
      dev_fall_n = n;
      dev_wait(HALF, ab);
      if (!ab) begin
        dev_clk = 1'b1;
        bits[n-1] = ps2_data_in;
        dev_wait(HALF / 2, ab);
        if (n == 10 && !nack) dev_data = 1'b0;
        if (!ab) dev_wait(HALF / 2, ab);
      end
    end
    if (ab) begin
      dev_clk = 1'b1;
      dev_data = 1'b1;
      dev_fall_n = 0;
      return;
    end
    if (exp_frame_q.size() == 0) begin
      check("unexpected_frame", {22'd0, bits}, 32'hFFFF_FFFF);
    end else begin
      ef = exp_frame_q.pop_front();
      check("frame_bits", {22'd0, bits}, {22'd0, ef});
    end
    dev_clk = 1'b0;
    dev_fall_n = 11;
    dev_wait(nack ? LONG : HALF, ab);
    dev_clk = 1'b1;
    dev_wait(HALF / 2, ab);
    dev_data = 1'b1;
    dev_fall_n = 0;
  endtask

  // device model: answers a request-to-send (clock released, data low)
  initial begin
    forever begin
      @(negedge CLK100MHZ);
      if (!dev_off && !rst && !dev_abort && !ps2_clk_oe && ps2_data_oe)
        dev_frame();
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!tx_ready && n < 10000) begin
      @(negedge CLK100MHZ);
      n++;
    end
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge CLK100MHZ);
    tx_valid = 1'b0;
    accept_cyc = cyc;
  endtask

  task automatic wait_done(input int start, input int budget);
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(negedge CLK100MHZ);
      n++;
    end
    if (done_cnt == start) check("done_wait_expired", 32'd0, 32'd1);
  endtask

  logic [7:0] vec_b[4];
  logic [9:0] vec_f[4];

  initial begin
    int d0, p0;
    vec_b[0] = 8'hF4; vec_f[0] = 10'b1_0_11110100;
    vec_b[1] = 8'hED; vec_f[1] = 10'b1_1_11101101;
    vec_b[2] = 8'hFF; vec_f[2] = 10'b1_1_11111111;
    vec_b[3] = 8'h81; vec_f[3] = 10'b1_1_10000001;

    repeat (5) @(negedge CLK100MHZ);
    check("reset_outputs",
          {26'd0, ps2_clk_oe, ps2_data_oe, busy, done, ack_ok, err_timeout},
          32'd0);
    rst = 1'b0;
    @(negedge CLK100MHZ);
    check("ready_after_reset", {31'd0, tx_ready}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      p0 = inh_phases;
      exp_frame_q.push_back(vec_f[i]);
      dev_mode_q.push_back(1'b0);
      exp_done_q.push_back(8'b1_0_1_1_0_0_00);
      send(vec_b[i]);
      if (i == 1) begin
        repeat (100) @(negedge CLK100MHZ);
        tx_data = 8'h00;
        tx_valid = 1'b1;
        repeat (50) @(negedge CLK100MHZ);
        tx_valid = 1'b0;
      end
      wait_done(d0, 5000);
      check("inhibit_len", inh_len, INH);
      check("inhibit_data_edge", {30'd0, inh_d_prev, inh_d_last}, 32'b01);
      repeat (200) @(negedge CLK100MHZ);
      check("one_attempt_idle", {inh_phases - p0, 31'd0, busy}, {32'd1, 32'd0});
    end

`ifndef PS2_TX_RETRY_EN
    d0 = done_cnt;
    exp_frame_q.push_back(10'b1_0_11110100);
    dev_mode_q.push_back(1'b1);
    exp_done_q.push_back(8'b0_0_1_1_0_0_00);
    send(8'hF4);
    wait_done(d0, 5000);
    repeat (50) @(negedge CLK100MHZ);

    d0 = done_cnt;
    dev_off = 1'b1;
    exp_done_q.push_back(8'b0_1_1_1_0_0_00);
    send(8'hFF);
    wait_done(d0, INH + REQT + 500);
    check("timeout_latency_ok",
          {31'd0, (done_cyc - accept_cyc >= INH + REQT - 2) &&
                  (done_cyc - accept_cyc <= INH + REQT + FILT + 4)}, 32'd1);
    dev_off = 1'b0;
    repeat (50) @(negedge CLK100MHZ);
`endif

    begin
      int n;
      d0 = done_cnt;
      send(8'hED);
      n = 0;
      while (dev_fall_n != 5 && n < 3000) begin
        @(negedge CLK100MHZ);
        n++;
      end
      check("reached_fall5", dev_fall_n, 5);
      rst = 1'b1;
      dev_abort = 1'b1;
      @(negedge CLK100MHZ);
      check("rst_release_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
      @(negedge CLK100MHZ);
      rst = 1'b0;
      @(negedge CLK100MHZ);
      check("rst_ready_idle", {30'd0, tx_ready, busy}, 32'b10);
      repeat (2000) @(negedge CLK100MHZ);
      check("rst_no_done", done_cnt - d0, 0);
      dev_abort = 1'b0;
    end

    d0 = done_cnt;
    exp_frame_q.push_back(10'b1_0_11110100);
    dev_mode_q.push_back(1'b0);
    exp_done_q.push_back(8'b1_0_1_1_0_0_00);
    send(8'hF4);
    wait_done(d0, 5000);
    repeat (50) @(negedge CLK100MHZ);

`ifdef PS2_TX_RETRY_EN
    d0 = done_cnt;
    p0 = inh_phases;
    for (int k = 0; k < 3; k++) exp_frame_q.push_back(10'b1_1_11101101);
    dev_mode_q.push_back(1'b1);
    dev_mode_q.push_back(1'b1);
    dev_mode_q.push_back(1'b0);
    exp_done_q.push_back(8'b1_0_1_1_0_0_10);
    send(8'hED);
    wait_done(d0, 15000);
    check("retry_inhibit_phases", inh_phases - p0, 3);
    repeat (50) @(negedge CLK100MHZ);
`endif

    check("scoreboard_drained",
          exp_done_q.size() + exp_frame_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
